hwpe_ctrl_regfile_bist_ctrl: RTL and testbench
==============================================

// Module: hwpe_ctrl_regfile_bist_ctrl
// PURPOSE
//  March C- built-in self-test sequencer for the HWPE control register file.
//  Drives the regfile test-wrapper BIST port (BIST/CSN_T/WEN_T/A_T/D_T/BE_T),
//  checks Q_T against expected data and reports pass/fail plus first failing
//  address/data. Sits beside the regfile wrapper; started by the HWPE
//  controller or a test-mode register.
// PARAMETERS
//  ADDR_WIDTH  5              regfile address width; N = 2**ADDR_WIDTH words
//  DATA_WIDTH  32             regfile word width
//  NUM_BYTE    DATA_WIDTH/8   byte enables per word
// PORTS
//  clk_i        in   1            clock
//  rst_ni       in   1            asynchronous active-low reset
//  clear_i      in   1            synchronous clear: abort, go IDLE, clear status
//  start_i      in   1            start request (sampled in IDLE only)
//  busy_o       out  1            test in progress
//  done_o       out  1            test finished (level, held until start/clear)
//  fail_o       out  1            mismatch detected (valid with done_o)
//  fail_addr_o  out  ADDR_WIDTH   address of first mismatch
//  fail_data_o  out  DATA_WIDTH   Q_T value read at first mismatch
//  bist_o       out  1            to BIST; high while busy_o
//  csn_o        out  1            to CSN_T, active-low chip select
//  wen_o        out  1            to WEN_T, 0=write 1=read
//  addr_o       out  ADDR_WIDTH   to A_T
//  wdata_o      out  DATA_WIDTH   to D_T
//  be_o         out  NUM_BYTE     to BE_T; constant all-ones
//  q_i          in   DATA_WIDTH   from Q_T
// BEHAVIOUR
//  - Reset/clear: IDLE; busy/done/fail/bist_o=0, csn_o=1, wen_o=1, addr_o=0,
//    wdata_o=0, fail_addr_o=0, fail_data_o=0, be_o='1. clear_i wins over start_i.
//  - All outputs registered. Read data: q_i valid in cycle after a read op
//    (1-cycle latency); compare happens in that cycle.
//  - FSM: IDLE -> RUN (start_i) -> DRAIN -> DONE; DONE -> RUN on start_i
//    (status cleared on accept). start_i while RUN/DRAIN ignored.
//  - First op driven the cycle after start_i accepted; busy_o rises then.
//  - RUN walks March elements, element index + address counter + op phase:
//    E0 up   W0          (1 cycle/addr)
//    E1 up   R0,W1       (2 cycles/addr: read, then write while comparing)
//    E2 up   R1,W0
//    E3 down R0,W1
//    E4 down R1,W0
//    E5 down R0          (1 cycle/addr)
//    0 = all-zeros, 1 = all-ones. up: 0..N-1; down: N-1..0.
//  - Address counter wraps at element end; no out-of-range address driven.
//  - Idle cycles between ops never occur: csn_o=0 every RUN cycle.
//  - DRAIN: 1 cycle, csn_o=1, compares last E5 read, then DONE.
//  - Mismatch (q_i != expected, any cycle where compare pending): capture
//    fail_addr_o/fail_data_o, set fail_o, abort: op in flight in that cycle
//    is suppressed (csn_o=1), next state DONE. Only first mismatch recorded.
//  - DONE: done_o=1, busy_o=0, bist_o=0, csn_o=1.
//  - Pass run length (no option): N + 8N + N + 1 = 10N+1 cycles busy.
// CONFIGURATION
//  HWPE_CTRL_BIST_CHECKERBOARD_EN defined: two extra elements after E5,
//    before DRAIN: E6 up W(cb), E7 down R(cb); cb = 0x55..55 on even addr,
//    0xAA..AA on odd addr. Pass run length 12N+1 cycles.
//  Undefined: E5 goes straight to DRAIN; no checkerboard logic present.
// TESTING
//  1 Fault-free regfile, N=32, start_i pulse -> busy_o 321 cycles (385 w/
//    macro), done_o=1, fail_o=0; csn/wen trace matches March sequence.
//  2 Bit 3 of addr 0x07 stuck-at-1 -> fail_o=1, fail_addr_o=0x07,
//    fail_data_o=0x00000008 (first E1 read), done_o within 1 cycle after.
//  3 Addr decoder fault (write to 0x1F also hits 0x00) -> fail_o=1,
//    fail_addr_o=0x00 detected in E3/E4 down pass.
//  4 clear_i asserted mid-E2 -> next cycle IDLE, bist_o=0, csn_o=1,
//    done_o=fail_o=0; start_i simultaneous with clear_i ignored.
//  5 start_i held high throughout run -> single run, then restart from DONE
//    clears status and repeats identical sequence.
//  6 Macro on, bit 0 of addr 0x02 stuck-at-0 only for cb pattern path ->
//    fail_addr_o=0x02, fail_data_o=0x55555554.

Source files
------------

// File: rtl/hwpe_ctrl_regfile_bist_ctrl_if.sv
// hwpe_ctrl_regfile_bist_ctrl_if: regfile test-wrapper BIST port (BIST/CSN_T/WEN_T/A_T/D_T/BE_T/Q_T)
interface hwpe_ctrl_regfile_bist_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE = DATA_WIDTH/8
);
  logic bist;
  logic csn;
  logic wen;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [NUM_BYTE-1:0] be;
  logic [DATA_WIDTH-1:0] q;
  modport master (output bist, csn, wen, addr, wdata, be, input q);
  modport slave (input bist, csn, wen, addr, wdata, be, output q);
endinterface

// File: rtl/hwpe_ctrl_regfile_bist_ctrl.sv
// hwpe_ctrl_regfile_bist_ctrl: March C- BIST sequencer for the HWPE control register file
// HWPE_CTRL_BIST_CHECKERBOARD_EN adds checkerboard elements E6 (up W) and E7 (down R).
module hwpe_ctrl_regfile_bist_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE = DATA_WIDTH/8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  output logic fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_data_o,
  hwpe_ctrl_regfile_bist_ctrl_if.master rf
);
`ifdef HWPE_CTRL_BIST_CHECKERBOARD_EN
  localparam logic [2:0] LAST_ELEM = 3'd7;
`else
  localparam logic [2:0] LAST_ELEM = 3'd5;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t r_state;
  logic [2:0] r_elem;
  logic r_ph, r_csn, r_wen, r_bist, r_busy, r_done, r_fail, r_pend;
  logic [ADDR_WIDTH-1:0] r_addr, r_cmp_addr, r_fail_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_exp, r_fail_data;
  logic w_down, w_step, w_end, w_last, w_ph, w_rd, w_mis;
  logic [2:0] w_elem;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  function automatic logic f_down(input logic [2:0] e);
    return (e > 3'd2) && (e != 3'd6);
  endfunction
  function automatic logic f_two(input logic [2:0] e);
    return (e != 3'd0) && (e < 3'd5);
  endfunction
  // Next op from the one on the bus; reads carry the expected word on wdata so it can be pipelined to the compare
  always_comb begin
    w_down = f_down(r_elem);
    w_step = !(f_two(r_elem) && !r_ph);
    w_end = w_down ? (r_addr == '0) : (r_addr == '1);
    w_last = w_step && w_end && (r_elem == LAST_ELEM);
    w_elem = (w_step && w_end) ? r_elem + 3'd1 : r_elem;
    w_ph = !w_step;
    w_addr = !w_step ? r_addr : w_end ? {ADDR_WIDTH{f_down(w_elem)}} : w_down ? r_addr - 1'b1 : r_addr + 1'b1;
    w_rd = f_two(w_elem) ? !w_ph : w_elem[0];
`ifdef HWPE_CTRL_BIST_CHECKERBOARD_EN
    w_wdata = (w_elem[2:1] == 2'b11) ? {(DATA_WIDTH/2){w_addr[0] ? 2'b10 : 2'b01}} : {DATA_WIDTH{w_rd ^ w_elem[0]}};
`else
    w_wdata = {DATA_WIDTH{w_rd ^ w_elem[0]}};
`endif
    w_mis = r_pend && (rf.q != r_exp);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_elem <= '0;
      r_ph <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_csn <= 1'b1;
      r_wen <= 1'b1;
      r_bist <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_fail <= 1'b0;
      r_pend <= 1'b0;
      r_exp <= '0;
      r_cmp_addr <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else if (clear_i) begin
      r_state <= IDLE;
      r_elem <= '0;
      r_ph <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_csn <= 1'b1;
      r_wen <= 1'b1;
      r_bist <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_fail <= 1'b0;
      r_pend <= 1'b0;
      r_exp <= '0;
      r_cmp_addr <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      r_pend <= 1'b0;
      r_exp <= r_wdata;
      r_cmp_addr <= r_addr;
      if (w_mis) begin
        r_fail <= 1'b1;
        r_fail_addr <= r_cmp_addr;
        r_fail_data <= rf.q;
      end
      case (r_state)
        IDLE, DONE: if (start_i) begin
          r_state <= RUN;
          r_elem <= '0;
          r_ph <= 1'b0;
          r_addr <= '0;
          r_wdata <= '0;
          r_csn <= 1'b0;
          r_wen <= 1'b0;
          r_bist <= 1'b1;
          r_busy <= 1'b1;
          r_done <= 1'b0;
          r_fail <= 1'b0;
          r_fail_addr <= '0;
          r_fail_data <= '0;
        end
        RUN: begin
          r_pend <= r_wen && !w_mis;
          if (w_mis) begin
            r_state <= DONE;
            r_csn <= 1'b1;
            r_wen <= 1'b1;
            r_bist <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else if (w_last) begin
            r_state <= DRAIN;
            r_csn <= 1'b1;
            r_wen <= 1'b1;
          end else begin
            r_elem <= w_elem;
            r_ph <= w_ph;
            r_addr <= w_addr;
            r_wen <= w_rd;
            r_wdata <= w_wdata;
          end
        end
        DRAIN: begin
          r_state <= DONE;
          r_bist <= 1'b0;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy_o = r_busy;
  assign done_o = r_done;
  assign fail_o = r_fail;
  assign fail_addr_o = r_fail_addr;
  assign fail_data_o = r_fail_data;
  assign rf.bist = r_bist;
  assign rf.csn = r_csn;
  assign rf.wen = r_wen;
  assign rf.addr = r_addr;
  assign rf.wdata = r_wdata;
  assign rf.be = {NUM_BYTE{1'b1}};
endmodule

// File: tb/tb_hwpe_ctrl_regfile_bist_ctrl.sv
// tb_hwpe_ctrl_regfile_bist_ctrl: faulty-regfile environment plus March C- reference model;
// the model walks the March element table to build the op list and the first mismatch.
module tb_hwpe_ctrl_regfile_bist_ctrl;
  localparam int AW = 5, DW = 32, NB = 4, N = 32;
`ifdef HWPE_CTRL_BIST_CHECKERBOARD_EN
  localparam bit CB = 1'b1;
`else
  localparam bit CB = 1'b0;
`endif
  localparam int NOPS = CB ? 12*N : 10*N;
  localparam int PASS_LEN = NOPS + 1;
  logic clk = 1'b0, rst_n = 1'b1, clear = 1'b0, start = 1'b0;
  logic busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  int tests = 0, fails = 0;
  int f_kind = 0, f_addr = 0, f_bit = 0, f_src = 0, f_dst = 0;
  logic [DW-1:0] mem [N];
  bit op_rd [NOPS];
  int op_a [NOPS];
  logic [DW-1:0] op_d [NOPS];
  int m_len, m_faddr, m_mode, m_cyc;
  bit m_fail;
  logic [DW-1:0] m_fdata;
  hwpe_ctrl_regfile_bist_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB)) rf();
  hwpe_ctrl_regfile_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
    .busy_o(busy), .done_o(done), .fail_o(fail),
    .fail_addr_o(fail_addr), .fail_data_o(fail_data), .rf(rf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // kinds: 1 stuck-at-1, 2 stuck-at-0, 3 write alias src->dst, 4 stuck-at-0 only while holding 0x55..55
  function automatic logic [DW-1:0] fault_rd(input logic [DW-1:0] v, input int a);
    logic [DW-1:0] m;
    m = '0;
    m[f_bit] = 1'b1;
    if (a != f_addr) return v;
    case (f_kind)
      1: return v | m;
      2: return v & ~m;
      4: return (v == {(DW/8){8'h55}}) ? v & ~m : v;
      default: return v;
    endcase
  endfunction
  always @(posedge clk) if (rf.bist && !rf.csn) begin
    if (!rf.wen) begin
      mem[rf.addr] <= rf.wdata;
      if (f_kind == 3 && int'(rf.addr) == f_src) mem[f_dst] <= rf.wdata;
    end else rf.q <= fault_rd(mem[rf.addr], int'(rf.addr));
  end
  function automatic logic [DW-1:0] pat(input byte c, input int a);
    return c == "c" ? ((a % 2) ? {(DW/8){8'hAA}} : {(DW/8){8'h55}}) : c == "1" ? {DW{1'b1}} : {DW{1'b0}};
  endfunction
  task automatic build_model();
    string el [8] = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0", "wc", "rc"};
    bit dn [8] = '{0, 0, 0, 1, 1, 1, 0, 1};
    logic [DW-1:0] mm [N];
    logic [DW-1:0] v, got;
    int k, fk;
    k = 0; fk = 0; m_fail = 0; m_faddr = 0; m_fdata = '0;
    foreach (mm[i]) mm[i] = '0;
    for (int e = 0; e < (CB ? 8 : 6); e++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < el[e].len()/2; j++) begin
          int a;
          a = dn[e] ? N-1-i : i;
          v = pat(el[e][2*j+1], a);
          op_rd[k] = el[e][2*j] == "r";
          op_a[k] = a;
          op_d[k] = v;
          if (op_rd[k]) begin
            got = fault_rd(mm[a], a);
            if (!m_fail && got !== v) begin m_fail = 1; m_faddr = a; m_fdata = got; fk = k; end
          end else begin
            mm[a] = v;
            if (f_kind == 3 && a == f_src) mm[f_dst] = v;
          end
          k++;
        end
    // a read is judged one cycle later, so a failing run drives one more op before DONE
    m_len = m_fail ? fk + 2 : PASS_LEN;
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin m_mode <= 0; m_cyc <= 0; end
    else if (clear) m_mode <= 0;
    else if (m_mode != 1 && start) begin m_mode <= 1; m_cyc <= 0; end
    else if (m_mode == 1) begin
      m_cyc <= m_cyc + 1;
      if (m_cyc + 1 == m_len) m_mode <= 2;
    end
  always @(negedge clk) if (rst_n) begin
    chk("be", rf.be, {NB{1'b1}});
    if (m_mode == 0) begin
      chk("idle_flags", {busy, done, fail, rf.bist, rf.csn, rf.wen}, 6'b000011);
      chk("idle_bus", {rf.addr, rf.wdata}, 0);
      chk("idle_status", {fail_addr, fail_data}, 0);
    end else if (m_mode == 1) begin
      chk("run_flags", {busy, done, fail, rf.bist}, 4'b1001);
      chk("run_status", {fail_addr, fail_data}, 0);
      if (m_cyc < NOPS) begin
        chk("op", {rf.csn, rf.wen, rf.addr}, {1'b0, op_rd[m_cyc], AW'(op_a[m_cyc])});
        if (!op_rd[m_cyc]) chk("wdata", rf.wdata, op_d[m_cyc]);
      end else chk("drain_csn", rf.csn, 1);
    end else begin
      chk("done_flags", {busy, done, rf.bist, rf.csn}, 4'b0101);
      chk("done_fail", {fail, fail_addr, fail_data}, {m_fail, m_fail ? AW'(m_faddr) : AW'(0), m_fail ? m_fdata : DW'(0)});
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic clean();
    clear = 1'b1; tick(); clear = 1'b0; tick();
  endtask
  task automatic set_fault(input int k, a, b, s, d);
    f_kind = k; f_addr = a; f_bit = b; f_src = s; f_dst = d;
    build_model();
  endtask
  task automatic go();
    start = 1'b1; tick(); start = 1'b0;
  endtask
  task automatic wait_done(output int nb);
    int g;
    nb = 0; g = 0;
    while (!done && g < 2000) begin
      if (busy) nb++;
      tick(); g++;
    end
    if (!done) chk("done_timeout", done, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int nb, g, rc, s;
    build_model();
    #1 rst_n = 1'b0;
    tick(3);
    chk("rst_flags", {busy, done, fail, rf.bist, rf.csn, rf.wen, rf.be}, {6'b000011, {NB{1'b1}}});
    chk("rst_bus", {rf.addr, rf.wdata}, 0);
    chk("rst_status", {fail_addr, fail_data}, 0);
    rst_n = 1'b1;
    tick(2);
    clean(); set_fault(0, 0, 0, 0, 0);
    chk("t1_model_len", m_len, CB ? 385 : 321);
    go(); wait_done(nb);
    chk("t1_busy_cycles", nb, CB ? 385 : 321);
    chk("t1_pass", {done, fail}, 2'b10);
    clean(); set_fault(1, 7, 3, 0, 0);
    chk("t2_model_addr", m_faddr, 7);
    chk("t2_model_data", m_fdata, 32'h8);
    chk("t2_model_len", m_len, 48);
    go(); wait_done(nb);
    chk("t2_fail", {fail, fail_addr, fail_data}, {1'b1, 5'h07, 32'h0000_0008});
    chk("t2_busy_cycles", nb, 48);
    clean(); set_fault(3, 0, 0, 31, 0);
    chk("t3_model_addr", m_faddr, 0);
    chk("t3_model_len", m_len, 224);
    go(); wait_done(nb);
    chk("t3_fail", {fail, fail_addr, fail_data}, {1'b1, 5'h00, 32'hFFFF_FFFF});
    clean(); set_fault(0, 0, 0, 0, 0);
    go(); tick(120);
    clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
    chk("t4_idle", {busy, done, fail, rf.bist, rf.csn}, 5'b00001);
    tick(3);
    chk("t4_stay_idle", {busy, done}, 2'b00);
    start = 1'b1; tick();
    wait_done(nb);
    chk("t5_busy_first", nb, CB ? 385 : 321);
    tick();
    chk("t5_restart", {busy, done, fail}, 3'b100);
    start = 1'b0;
    wait_done(nb);
    chk("t5_busy_second", nb, CB ? 385 : 321);
    clean(); set_fault(4, 2, 0, 0, 0);
`ifdef HWPE_CTRL_BIST_CHECKERBOARD_EN
    chk("t6_model_len", m_len, 383);
    go(); wait_done(nb);
    chk("t6_fail", {fail, fail_addr, fail_data}, {1'b1, 5'h02, 32'h5555_5554});
`else
    chk("t6_model_pass", m_fail, 0);
    go(); wait_done(nb);
    chk("t6_pass", {done, fail}, 2'b10);
`endif
    for (int it = 0; it < 12; it++) begin
      clean();
      s = $urandom_range(0, N-1);
      set_fault($urandom_range(0, CB ? 4 : 3), $urandom_range(0, N-1), $urandom_range(0, DW-1), s, (s + $urandom_range(1, N-1)) % N);
      rc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 300) : -1;
      go();
      g = 0;
      while (!done && g < 2000) begin
        if (g == rc) begin
          clear = 1'b1; start = 1'($urandom_range(0, 1)); tick(); clear = 1'b0; start = 1'b0;
          break;
        end
        start = ($urandom_range(0, 7) == 0);
        tick(); start = 1'b0; g++;
      end
      if (rc < 0) chk("rand_done", done, 1);
      tick(2);
    end
    clean();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
